traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
- Timed phase sequencer that generates the 5-bit phase code consumed by the 5-to-32 one-hot lamp decoder directly downstream.
- Bit phase_code[4] drives decoder input A, and bit [0] drives input E.
- Steps through NUM_PHASES phases, each held for a programmable dwell measured in prescaled ticks.
- Supports a pedestrian-request insertion and a night flashing mode.

Parameters:
- NUM_PHASES, 8, number of normal phases cycled (2..32); codes 0..NUM_PHASES-1.
- TICK_DIV, 1000, clock cycles per dwell tick (>=2).
- DEFAULT_DWELL, 4, reset value of every dwell-table entry (1..255).
- PED_PHASE, 31, phase code inserted on a pedestrian request.
- FLASH_ON, 30, code shown during the "on" half of night flashing.
- FLASH_OFF, 29, code shown during the "off" half of night flashing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run the sequencer; 0 = synchronous return to IDLE.
- night_mode  in  1  request flashing mode.
- ped_req  in  1  pedestrian request, level-sampled every cycle.
- cfg_we  in  1  dwell-table write strobe.
- cfg_addr  in  5  dwell-table entry index.
- cfg_dwell  in  8  dwell value in ticks.
- phase_code  out  5  current phase code to the decoder.
- phase_start  out  1  one-cycle pulse in the first cycle of every new phase code.
- remaining  out  8  ticks left in the current phase.
- ped_ack  out  1  one-cycle pulse when PED_PHASE is entered.
- busy  out  1  1 when the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; phase_code=0, remaining=0, phase_start=0, ped_ack=0, busy=0.
  - Prescaler=0, ped_pending=0, return_phase=0, every dwell entry=DEFAULT_DWELL.
- Dwell table:
  - cfg_we=1 with cfg_addr<NUM_PHASES writes cfg_dwell to that entry at the clock edge.
  - Writes with cfg_addr>=NUM_PHASES are ignored.
  - Writes are accepted in any state.
  - A write affects only later loads of that entry; a countdown already in progress is unchanged.
  - A dwell of 0 is loaded as 1.
  - PED_PHASE always uses entry 0's dwell.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 when the count is TICK_DIV-1.
  - Forced to 0 in IDLE and on every phase load.
  - Every phase is therefore held exactly dwell*TICK_DIV cycles.
- IDLE: when enable=1, the next edge goes to RUN and loads phase 0 (remaining=dwell[0], phase_start=1).
- RUN, on tick:
  - remaining>1: decrement remaining.
  - remaining==1: phase boundary. First matching rule applies:
    - (a) night_mode=1: go to FLASH, phase_code=FLASH_ON, remaining=0.
    - (b) ped_pending=1 and current phase is not PED_PHASE:
      - return_phase = next normal phase;
      - load PED_PHASE; ped_ack=1; clear ped_pending.
    - (c) current phase is PED_PHASE: load return_phase.
    - (d) otherwise: load cur+1, wrapping NUM_PHASES-1 to 0.
  - Every load pulses phase_start=1.
- ped_pending:
  - Set by ped_req=1 in RUN, except while phase_code==PED_PHASE.
  - A request that coincides with a boundary tick is honoured at that same boundary.
  - ped_req is ignored in IDLE and FLASH.
- FLASH:
  - On each tick, phase_code toggles FLASH_ON<->FLASH_OFF, with phase_start=1 on every toggle.
  - If night_mode=0 at a tick, go to RUN and load phase 0 instead of toggling.
- enable=0 in any non-IDLE state: the next edge forces IDLE with all outputs and internal state at their reset values, except the dwell table, which is retained.
- Outputs are registered, with no combinational path from inputs to outputs.
- Precedence at a single edge: enable=0 > boundary logic > ped_req latch.

Test Plan:
- TICK_DIV=2, NUM_PHASES=4, defaults; release reset, enable=1 → phase_code sequence 0,1,2,3,0, each code held exactly 8 cycles; phase_start pulses once per change; remaining counts 4,3,2,1.
- Write cfg_addr=2, cfg_dwell=1 while in phase 2 → current phase 2 still lasts 8 cycles; the next phase 2 lasts 2 cycles. A write to cfg_addr=7 has no effect.
- Pulse ped_req during phase 1 → at the end of phase 1, phase_code=31 for 8 cycles with ped_ack pulsed once, then phase 2. A ped_req asserted during phase 31 is not re-honoured.
- ped_req asserted exactly on the boundary tick of phase 3 → next code 31, then return to 0.
- night_mode=1 during phase 0 → at the boundary, codes toggle 30,29,30 every 2 cycles; night_mode=0 → phase 0 loads at the next tick.
- Drop enable mid-phase, and separately assert rst_n=0 asynchronously mid-phase → the outputs show reset values (code 0, busy=0). After enable only the dwell table is retained; after rst_n it returns to DEFAULT_DWELL.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Timed phase sequencer feeding the 5-to-32 one-hot lamp decoder.
// Cycles through NUM_PHASES normal phases, each held for a programmable
// number of prescaled ticks, with pedestrian-phase insertion and a night
// flashing mode. All outputs come straight from registers.
module traffic_phase_sequencer #(
    parameter int NUM_PHASES    = 8,
    parameter int TICK_DIV      = 1000,
    parameter int DEFAULT_DWELL = 4,
    parameter int PED_PHASE     = 31,
    parameter int FLASH_ON      = 30,
    parameter int FLASH_OFF     = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       night_mode,
    input  logic       ped_req,
    input  logic       cfg_we,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_dwell,
    output logic [4:0] phase_code,
    output logic       phase_start,
    output logic [7:0] remaining,
    output logic       ped_ack,
    output logic       busy
);

    localparam int AW = $clog2(NUM_PHASES);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLASH = 2'd2
    } state_t;

    state_t       state_q;
    logic [PW-1:0] prescale_q;
    logic [4:0]   phaseCode_q;
    logic [7:0]   remaining_q;
    logic         phaseStart_q;
    logic         pedAck_q;
    logic         busy_q;
    logic         pedPending_q;
    logic [4:0]   returnPhase_q;
    logic [7:0]   dwell_q [NUM_PHASES];

    logic         tick;
    logic [4:0]   nextNormal;
    logic         pedReqEff;
    logic         wantPed;
    logic [7:0]   dwellZero;
    logic [7:0]   dwellNext;
    logic [7:0]   dwellReturn;

    // A zero dwell would never expire, so it is stretched to one tick.
    function automatic logic [7:0] loadDwell(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    // Tick detection, successor phase and the dwell values each load would use.
    always_comb begin
        tick        = (prescale_q == PW'(TICK_DIV - 1));
        nextNormal  = (phaseCode_q == 5'(NUM_PHASES - 1)) ? 5'd0 : phaseCode_q + 5'd1;
        pedReqEff   = ped_req && (phaseCode_q != 5'(PED_PHASE));
        wantPed     = (pedPending_q || pedReqEff) && (phaseCode_q != 5'(PED_PHASE));
        dwellZero   = loadDwell(dwell_q[0]);
        dwellNext   = loadDwell(dwell_q[AW'(nextNormal)]);
        dwellReturn = loadDwell(dwell_q[AW'(returnPhase_q)]);
    end

    // Dwell table: survives enable=0, only rst_n restores the defaults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                dwell_q[i] <= 8'(DEFAULT_DWELL);
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < 6'(NUM_PHASES))) begin
            dwell_q[AW'(cfg_addr)] <= cfg_dwell;
        end
    end

    // Sequencer FSM with prescaler, pedestrian latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prescale_q    <= '0;
            phaseCode_q   <= 5'd0;
            remaining_q   <= 8'd0;
            phaseStart_q  <= 1'b0;
            pedAck_q      <= 1'b0;
            busy_q        <= 1'b0;
            pedPending_q  <= 1'b0;
            returnPhase_q <= 5'd0;
        end else begin
            phaseStart_q <= 1'b0;
            pedAck_q     <= 1'b0;
            if (!enable) begin
                state_q       <= IDLE;
                prescale_q    <= '0;
                phaseCode_q   <= 5'd0;
                remaining_q   <= 8'd0;
                busy_q        <= 1'b0;
                pedPending_q  <= 1'b0;
                returnPhase_q <= 5'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        prescale_q   <= '0;
                        phaseCode_q  <= 5'd0;
                        remaining_q  <= dwellZero;
                        phaseStart_q <= 1'b1;
                    end
                    RUN: begin
                        prescale_q <= tick ? '0 : prescale_q + PW'(1);
                        if (pedReqEff) begin
                            pedPending_q <= 1'b1;
                        end
                        if (tick) begin
                            if (remaining_q > 8'd1) begin
                                remaining_q <= remaining_q - 8'd1;
                            end else if (night_mode) begin
                                state_q      <= FLASH;
                                phaseCode_q  <= 5'(FLASH_ON);
                                remaining_q  <= 8'd0;
                                phaseStart_q <= 1'b1;
                            end else if (wantPed) begin
                                returnPhase_q <= nextNormal;
                                phaseCode_q   <= 5'(PED_PHASE);
                                remaining_q   <= dwellZero;
                                phaseStart_q  <= 1'b1;
                                pedAck_q      <= 1'b1;
                                pedPending_q  <= 1'b0;
                            end else if (phaseCode_q == 5'(PED_PHASE)) begin
                                phaseCode_q  <= returnPhase_q;
                                remaining_q  <= dwellReturn;
                                phaseStart_q <= 1'b1;
                            end else begin
                                phaseCode_q  <= nextNormal;
                                remaining_q  <= dwellNext;
                                phaseStart_q <= 1'b1;
                            end
                        end
                    end
                    FLASH: begin
                        prescale_q <= tick ? '0 : prescale_q + PW'(1);
                        if (tick) begin
                            phaseStart_q <= 1'b1;
                            if (!night_mode) begin
                                state_q     <= RUN;
                                phaseCode_q <= 5'd0;
                                remaining_q <= dwellZero;
                            end else if (phaseCode_q == 5'(FLASH_ON)) begin
                                phaseCode_q <= 5'(FLASH_OFF);
                            end else begin
                                phaseCode_q <= 5'(FLASH_ON);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign phase_code  = phaseCode_q;
    assign phase_start = phaseStart_q;
    assign remaining   = remaining_q;
    assign ped_ack     = pedAck_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with TICK_DIV=2, NUM_PHASES=4,
// so every default phase lasts 8 cycles and remaining reads 4,4,3,3,2,2,1,1.
module tb_traffic_phase_sequencer;

    localparam int NP = 4;
    localparam int TD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       night_mode = 1'b0;
    logic       ped_req = 1'b0;
    logic       cfg_we = 1'b0;
    logic [4:0] cfg_addr = 5'd0;
    logic [7:0] cfg_dwell = 8'd0;
    logic [4:0] phase_code;
    logic       phase_start;
    logic [7:0] remaining;
    logic       ped_ack;
    logic       busy;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       en;
        logic       night;
        logic       ped;
        logic [4:0] code;
        logic       start;
        logic [7:0] rem;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t vecs [40];

    traffic_phase_sequencer #(
        .NUM_PHASES   (NP),
        .TICK_DIV     (TD),
        .DEFAULT_DWELL(4),
        .PED_PHASE    (31),
        .FLASH_ON     (30),
        .FLASH_OFF    (29)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .night_mode (night_mode),
        .ped_req    (ped_req),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_dwell  (cfg_dwell),
        .phase_code (phase_code),
        .phase_start(phase_start),
        .remaining  (remaining),
        .ped_ack    (ped_ack),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Compare every output against the expected set in one check.
    task automatic checkOutput(input string name, input logic [4:0] eCode, input logic eStart,
                               input logic [7:0] eRem, input logic eAck, input logic eBusy);
        checkCount++;
        if (phase_code === eCode && phase_start === eStart && remaining === eRem &&
            ped_ack === eAck && busy === eBusy) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s @%0t: got code=%0d start=%0b rem=%0d ack=%0b busy=%0b, expected code=%0d start=%0b rem=%0d ack=%0b busy=%0b",
                     name, $time, phase_code, phase_start, remaining, ped_ack, busy,
                     eCode, eStart, eRem, eAck, eBusy);
        end
    endtask

    // Drive the run-time inputs and advance to just after the next rising edge.
    task automatic applyStimulus(input logic en, input logic night, input logic ped);
        enable     = en;
        night_mode = night;
        ped_req    = ped;
        @(posedge clk);
        #1;
    endtask

    // Check cycles kFrom..kTo-1 of a phase of the given dwell; optionally pulse
    // ped_req or a table write after the check of cycle pedAt / cfgAt.
    task automatic expectPhase(input string name, input logic [4:0] code, input int dwell,
                               input logic ack, input int kFrom, input int kTo,
                               input int pedAt, input int cfgAt,
                               input logic [4:0] addr, input logic [7:0] val);
        int last;
        last = (kTo < 0) ? dwell * TD : kTo;
        for (int k = kFrom; k < last; k++) begin
            @(posedge clk);
            #1;
            checkOutput(name, code, (k == 0), 8'(dwell - k / TD), ack && (k == 0), 1'b1);
            ped_req   = (k == pedAt);
            cfg_we    = (k == cfgAt);
            cfg_addr  = addr;
            cfg_dwell = val;
        end
    endtask

    initial begin
        for (int k = 0; k < 40; k++) begin
            vecs[k].en    = 1'b1;
            vecs[k].night = 1'b0;
            vecs[k].ped   = 1'b0;
            vecs[k].code  = 5'((k / 8) % 4);
            vecs[k].start = ((k % 8) == 0);
            vecs[k].rem   = 8'(4 - (k % 8) / 2);
            vecs[k].ack   = 1'b0;
            vecs[k].busy  = 1'b1;
        end

        #2;
        checkOutput("reset_state", 5'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        #12 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_disabled", 5'd0, 1'b0, 8'd0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(vecs[k].en, vecs[k].night, vecs[k].ped);
            checkOutput($sformatf("base_seq[%0d]", k), vecs[k].code, vecs[k].start,
                        vecs[k].rem, vecs[k].ack, vecs[k].busy);
        end

        expectPhase("ped_in_p1",       5'd1,  4, 1'b0, 0, -1,  3, -1, 5'd0, 8'd0);
        expectPhase("ped_phase",       5'd31, 4, 1'b1, 0, -1,  2, -1, 5'd0, 8'd0);
        expectPhase("p2_after_ped",    5'd2,  4, 1'b0, 0, -1, -1,  2, 5'd2, 8'd1);
        expectPhase("p3_boundary_ped", 5'd3,  4, 1'b0, 0, -1,  7,  2, 5'd7, 8'd1);
        expectPhase("ped_boundary",    5'd31, 4, 1'b1, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("return_p0",       5'd0,  4, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("p1",              5'd1,  4, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("p2_short",        5'd2,  1, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("addr7_ignored",   5'd3,  4, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);

        expectPhase("p0_pre_night",    5'd0,  4, 1'b0, 0,  3, -1, -1, 5'd0, 8'd0);
        night_mode = 1'b1;
        expectPhase("p0_night_req",    5'd0,  4, 1'b0, 3, -1, -1, -1, 5'd0, 8'd0);
        for (int f = 0; f < 6; f++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("flash[%0d]", f), ((f / 2) % 2 == 0) ? 5'd30 : 5'd29,
                        ((f % 2) == 0), 8'd0, 1'b0, 1'b1);
            if (f == 4) night_mode = 1'b0;
        end
        expectPhase("after_flash",     5'd0,  4, 1'b0, 0,  3, -1, -1, 5'd0, 8'd0);

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("enable_drop", 5'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("enable_idle", 5'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        enable = 1'b1;
        expectPhase("reenable_p0",     5'd0,  4, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("reenable_p1",     5'd1,  4, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("table_retained",  5'd2,  1, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("p3_pre_reset",    5'd3,  4, 1'b0, 0,  3, -1, -1, 5'd0, 8'd0);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 5'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 5'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expectPhase("post_reset_p0",   5'd0,  4, 1'b0, 0, -1, -1,  2, 5'd1, 8'd0);
        expectPhase("dwell_zero_p1",   5'd1,  1, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);
        expectPhase("default_restored",5'd2,  4, 1'b0, 0, -1, -1, -1, 5'd0, 8'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
